// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end constants and helpers.
package rv32i_pkg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [XLEN-1:0]    PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/rv32i_fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time and filled
// in the same order as memory returns data.
module rv32i_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic                    fill,
  input  logic [INSTR_W-1:0]      fill_data,
  input  logic                    pop,
  output logic                    head_filled,
  output logic [XLEN-1:0]         head_pc,
  output logic [INSTR_W-1:0]      head_instr,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  unfilled
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]    pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]   filled_q;
  logic [PW-1:0]      head_q, tail_q, fptr_q;
  logic [CW-1:0]      count_q, unf_q;
  logic               do_fill;

  // Fills during a flush belong to squashed entries; the top accounts for them.
  assign do_fill = fill && !flush && (unf_q != '0);

  always_ff @(posedge clk) begin
    if (push)    pc_q[tail_q]    <= push_pc;
    if (do_fill) instr_q[fptr_q] <= fill_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      count_q  <= '0;
      unf_q    <= '0;
      filled_q <= '0;
    end else if (flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      count_q  <= '0;
      unf_q    <= '0;
      filled_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (do_fill) begin
        fptr_q           <= fptr_q + PW'(1);
        filled_q[fptr_q] <= 1'b1;
      end
      if (pop) begin
        head_q           <= head_q + PW'(1);
        filled_q[head_q] <= 1'b0;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      unf_q   <= unf_q + CW'(push) - CW'(do_fill);
    end
  end

  assign head_filled = filled_q[head_q];
  assign head_pc     = pc_q[head_q];
  assign head_instr  = instr_q[head_q];
  assign count       = count_q;
  assign unfilled    = unf_q;
endmodule

// File: rtl/rv32i_fetch_unit.sv
// Fetch stage: credit-limited imem requests, PC load control, redirect
// squash via a drop counter for responses still in flight.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    pc_in,
  output logic               pc_ld,
  output logic [XLEN-1:0]    pc_next,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      q_count, q_unfilled, drop_q, drop_d;
  logic [CW:0]        inflight;
  logic               head_filled, credit, req_acc, rsp_fill, pop;
  logic [XLEN-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign inflight = {1'b0, q_count} + {1'b0, drop_q};
  assign credit   = inflight < (CW+1)'(DEPTH);

  always_comb begin
    imem_req_valid = !reset && !redirect_valid && credit;
    req_acc        = imem_req_valid && imem_req_ready;
    if_valid       = !reset && head_filled && !redirect_valid;
    pop            = if_valid && if_ready;
    rsp_fill       = imem_rsp_valid && (drop_q == '0);
    pc_ld          = 1'b1;
    pc_next        = pc_in;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (req_acc) begin
      pc_ld   = 1'b0;
      pc_next = pc_in + PC_STEP;
    end
    drop_d = drop_q;
    // Squashed unfilled entries become drops, minus any response landing now.
    if (redirect_valid)
      drop_d = drop_q + q_unfilled - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_q != '0))
      drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  rv32i_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .push        (req_acc),
    .push_pc     (pc_in),
    .fill        (rsp_fill),
    .fill_data   (imem_rsp_data),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .count       (q_count),
    .unfilled    (q_unfilled)
  );

  assign imem_req_addr = word_align(pc_in);
  assign if_pc         = head_pc;
  assign if_instr      = head_filled ? head_instr : NOP;

  rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (drop_q != '0 || q_unfilled != '0));
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: PC register + variable-latency memory model,
// scoreboard of expected {pc, instr} checked by a negedge monitor.
module tb_rv32i_fetch_unit;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk, reset;
  logic [31:0] pc_reg;
  logic        pc_ld;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;

  rv32i_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_reg),
    .pc_ld          (pc_ld),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  int          total = 0, bad = 0, n_pop = 0, pops_before = 0;
  int unsigned cyc = 0, lat = 1;

  always @(posedge clk) pc_reg <= pc_ld ? pc_next : pc_reg + 32'd4;

  // In-order memory; a request accepted in cycle N returns in cycle N+lat.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready)
        pend.push_back('{imem_req_addr, cyc + lat - 1});
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = e.pc ^ KEY;
      sb.push_back(e);
    end
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && if_valid && if_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL if_unexpected: got pc %h want no handshake", if_pc);
        end else begin
          e = sb.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_instr", if_instr, e.instr);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; if_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_pc_ld", 32'(pc_ld), 32'd1);
    check("rst_pc_next", pc_next, RST_PC);

    // Streaming with a 1-cycle memory
    expect_seq(RST_PC, 64);
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
    edge_drive(); reset = 1'b0;
    @(negedge clk);
    check("a_req_valid", 32'(imem_req_valid), 32'd1);
    check("a_addr", imem_req_addr, RST_PC);
    check("a_pc_ld", 32'(pc_ld), 32'd0);
    @(negedge clk);
    check("b_addr", imem_req_addr, RST_PC + 32'd4);
    check("b_pc_ld", 32'(pc_ld), 32'd0);
    @(negedge clk);
    check("c_if_valid", 32'(if_valid), 32'd1);
    check("c_req_full", 32'(imem_req_valid), 32'd0);
    repeat (27) @(negedge clk);
    check("stream_pops", 32'(n_pop >= 15), 32'd1);

    // Decode stall for 5 cycles
    edge_drive(); if_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_pc_ld", 32'(pc_ld), 32'd1);
      check("stall_pc_hold", pc_next, pc_reg);
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_pc", if_pc, sb[0].pc);
      check("stall_if_instr", if_instr, sb[0].instr);
    end
    edge_drive(); if_ready = 1'b1;
    repeat (15) @(negedge clk);

    // Redirect with two requests outstanding on a slow memory
    edge_drive(); imem_req_ready = 1'b0;
    repeat (10) @(negedge clk);
    lat = 5;
    edge_drive(); imem_req_ready = 1'b1;
    @(negedge clk);
    check("r1_req0", 32'(imem_req_valid), 32'd1);
    edge_drive();
    @(negedge clk);
    check("r1_req1", 32'(imem_req_valid), 32'd1);
    edge_drive();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    sb.delete(); expect_seq(32'h100, 16); pops_before = n_pop;
    @(negedge clk);
    check("r1_if_valid", 32'(if_valid), 32'd0);
    check("r1_req_valid", 32'(imem_req_valid), 32'd0);
    check("r1_pc_ld", 32'(pc_ld), 32'd1);
    check("r1_pc_next", pc_next, 32'h100);
    edge_drive(); redirect_valid = 1'b0; lat = 1;
    @(negedge clk);
    check("r1_drop_block", 32'(imem_req_valid), 32'd0);
    check("r1_pc_held", pc_next, 32'h100);
    repeat (2) @(negedge clk);
    check("r1_drop_block2", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("r1_restart", 32'(imem_req_valid), 32'd1);
    check("r1_restart_addr", imem_req_addr, 32'h100);
    repeat (15) @(negedge clk);
    check("r1_progress", 32'(n_pop - pops_before >= 4), 32'd1);

    // Redirect coinciding with a response and a would-be handshake; unaligned target
    edge_drive(); imem_req_ready = 1'b0;
    repeat (10) @(negedge clk);
    edge_drive(); imem_req_ready = 1'b1;
    edge_drive();
    edge_drive();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    sb.delete(); expect_seq(32'h200, 16); pops_before = n_pop;
    @(negedge clk);
    check("r2_rsp_now", 32'(imem_rsp_valid), 32'd1);
    check("r2_if_valid", 32'(if_valid), 32'd0);
    check("r2_req_valid", 32'(imem_req_valid), 32'd0);
    check("r2_pc_next", pc_next, 32'h200);
    edge_drive(); redirect_valid = 1'b0;
    @(negedge clk);
    check("r2_restart", 32'(imem_req_valid), 32'd1);
    check("r2_addr", imem_req_addr, 32'h200);
    repeat (15) @(negedge clk);
    check("r2_progress", 32'(n_pop - pops_before >= 4), 32'd1);

    // Asynchronous reset with entries filled and outstanding
    edge_drive(); lat = 3; if_ready = 1'b0;
    repeat (4) @(negedge clk);
    edge_drive(); reset = 1'b1;
    #1;
    check("ar_if_valid", 32'(if_valid), 32'd0);
    check("ar_req_valid", 32'(imem_req_valid), 32'd0);
    check("ar_pc_ld", 32'(pc_ld), 32'd1);
    check("ar_pc_next", pc_next, RST_PC);
    sb.delete(); expect_seq(RST_PC, 32); pops_before = n_pop;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; if_ready = 1'b1; lat = 1;
    @(negedge clk);
    check("ar_restart", 32'(imem_req_valid), 32'd1);
    check("ar_addr", imem_req_addr, RST_PC);
    repeat (20) @(negedge clk);
    check("ar_progress", 32'(n_pop - pops_before >= 8), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
